// File: rtl/editor_mapa_pkg.sv
// editor_mapa_pkg: shared definitions for the LED-matrix bitmap editor.
//   - Matrix geometry (N_COLS x N_ROWS) and cursor widths.
//   - State encoding for the LOCKED/EDIT controller.
//   - Button index names.
//   - The four preset bitmaps and a selector function.
// A mapa_t element [c] is column c; bit r of a column drives row l_r (1 = LED on).
package editor_mapa_pkg;

  localparam int unsigned N_COLS = 5;
  localparam int unsigned N_ROWS = 7;
  localparam int unsigned COL_W  = 3;
  localparam int unsigned ROW_W  = 3;
  localparam int unsigned N_BTNS = 4;

  localparam int unsigned BTN_DIR    = 0;
  localparam int unsigned BTN_DOWN   = 1;
  localparam int unsigned BTN_TOGGLE = 2;
  localparam int unsigned BTN_PRESET = 3;

  localparam logic [0:0] LOCKED = 1'b0;
  localparam logic [0:0] EDIT   = 1'b1;

  typedef logic [N_COLS-1:0][N_ROWS-1:0] mapa_t;

  // Concatenations list column 4 first so that element [0] is column 0.
  localparam mapa_t PRESET_0 = {7'b1000011, 7'b1110001, 7'b1000101, 7'b0001100, 7'b0000100};
  localparam mapa_t PRESET_1 = {7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000};
  localparam mapa_t PRESET_2 = {7'b1111111, 7'b1000001, 7'b1000001, 7'b1000001, 7'b1111111};
  localparam mapa_t PRESET_3 = {7'b1010101, 7'b0101010, 7'b1010101, 7'b0101010, 7'b1010101};

  function automatic mapa_t preset_map(input logic [1:0] sel);
    mapa_t m;
    case (sel)
      2'd0:    m = PRESET_0;
      2'd1:    m = PRESET_1;
      2'd2:    m = PRESET_2;
      default: m = PRESET_3;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/editor_mapa_debounce_botao.sv
// debounce_botao: conditions one raw active-low push button.
//   clk_i      board clock
//   reset      asynchronous active-high reset
//   btn_raw_i  raw button level, asynchronous to clk_i (0 = pressed)
//   level_o    debounced level (resets to released = 1)
//   press_o    one-cycle pulse when the debounced level falls 1 -> 0
// A new synchronized level must persist for DB_CYCLES consecutive cycles before it
// is accepted; any return to the current stable level restarts the count.
module debounce_botao #(
  parameter int unsigned DB_CYCLES = 500000,
  parameter int unsigned DB_W      = 19
) (
  input  logic clk_i,
  input  logic reset,
  input  logic btn_raw_i,
  output logic level_o,
  output logic press_o
);

  localparam logic [DB_W-1:0] CntLast = DB_W'(DB_CYCLES - 1);

  logic            sync_meta_q, sync_q;
  logic            stable_q, stable_d;
  logic            press_q, press_d;
  logic [DB_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    press_d  = 1'b0;
    if (sync_q != stable_q) begin
      if (cnt_q == CntLast) begin
        stable_d = sync_q;
        press_d  = ~sync_q;  // only the 1 -> 0 edge is a press
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      sync_meta_q <= 1'b1;
      sync_q      <= 1'b1;
      stable_q    <= 1'b1;
      press_q     <= 1'b0;
      cnt_q       <= '0;
    end else begin
      sync_meta_q <= btn_raw_i;
      sync_q      <= sync_meta_q;
      stable_q    <= stable_d;
      press_q     <= press_d;
      cnt_q       <= cnt_d;
    end
  end

  assign level_o = stable_q;
  assign press_o = press_q;

endmodule

// File: rtl/editor_mapa.sv
// editor_mapa: generates and holds the 5x7 bitmap scanned by matriz_leds.
//   clock_in     board clock
//   reset        asynchronous active-high reset
//   btn[3:0]     raw active-low buttons: 0 column step, 1 row step, 2 toggle, 3 preset
//   ch[7:0]      raw switches: [1:0] preset select, [7] edit mode
//   blink_tick   one-cycle cursor blink pulse
//   mapa0..4     column bitmaps, bit i drives row l_i
//   cursor_col   cursor column 0..4
//   cursor_row   cursor row 0..6
//   modo_edicao  high while in EDIT
// Build option: define CURSOR_BLINK_EN to invert the cursor pixel on the outputs
// during the odd blink phase (EDIT only); otherwise blink_tick is ignored.
module editor_mapa
  import editor_mapa_pkg::*;
#(
  parameter int unsigned DB_CYCLES = 500000,
  parameter int unsigned DB_W      = 19
) (
  input  logic             clock_in,
  input  logic             reset,
  input  logic [3:0]       btn,
  input  logic [7:0]       ch,
  input  logic             blink_tick,
  output logic [6:0]       mapa0,
  output logic [6:0]       mapa1,
  output logic [6:0]       mapa2,
  output logic [6:0]       mapa3,
  output logic [6:0]       mapa4,
  output logic [COL_W-1:0] cursor_col,
  output logic [ROW_W-1:0] cursor_row,
  output logic             modo_edicao
);

  logic [N_BTNS-1:0] press;
  logic [N_BTNS-1:0] level;

  for (genvar i = 0; i < N_BTNS; i++) begin : g_btn
    debounce_botao #(
      .DB_CYCLES(DB_CYCLES),
      .DB_W     (DB_W)
    ) u_debounce (
      .clk_i    (clock_in),
      .reset    (reset),
      .btn_raw_i(btn[i]),
      .level_o  (level[i]),
      .press_o  (press[i])
    );
  end

  // Edit-mode switch: synchronized only, no debounce.
  logic edit_meta_q, edit_sync_q;
  logic [0:0] state_q, state_d;
  logic edit;

  assign state_d = edit_sync_q ? EDIT : LOCKED;
  assign edit    = (state_q == EDIT);

  mapa_t            mapa_q, mapa_d, mapa_out;
  logic [COL_W-1:0] cursor_col_q, cursor_col_d;
  logic [ROW_W-1:0] cursor_row_q, cursor_row_d;
  logic [N_ROWS-1:0] row_mask;

  assign row_mask = N_ROWS'(1) << cursor_row_q;

  always_comb begin
    mapa_d       = mapa_q;
    cursor_col_d = cursor_col_q;
    cursor_row_d = cursor_row_q;
    // Preset load is accepted in both states and suppresses a same-cycle toggle.
    if (press[BTN_PRESET]) begin
      mapa_d = preset_map(ch[1:0]);
    end else if (edit && press[BTN_TOGGLE]) begin
      for (int unsigned c = 0; c < N_COLS; c++) begin
        if (cursor_col_q == COL_W'(c)) mapa_d[c] = mapa_q[c] ^ row_mask;
      end
    end
    // Moves are registered, so a same-cycle toggle above used the old position.
    if (edit && press[BTN_DIR]) begin
      cursor_col_d = (cursor_col_q == COL_W'(N_COLS - 1)) ? '0 : cursor_col_q + 1'b1;
    end
    if (edit && press[BTN_DOWN]) begin
      cursor_row_d = (cursor_row_q == ROW_W'(N_ROWS - 1)) ? '0 : cursor_row_q + 1'b1;
    end
  end

  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      edit_meta_q  <= 1'b0;
      edit_sync_q  <= 1'b0;
      state_q      <= LOCKED;
      mapa_q       <= PRESET_0;
      cursor_col_q <= '0;
      cursor_row_q <= '0;
    end else begin
      edit_meta_q  <= ch[7];
      edit_sync_q  <= edit_meta_q;
      state_q      <= state_d;
      mapa_q       <= mapa_d;
      cursor_col_q <= cursor_col_d;
      cursor_row_q <= cursor_row_d;
    end
  end

`ifdef CURSOR_BLINK_EN
  // Phase is forced to 0 outside EDIT, so every entry into EDIT starts at 0.
  logic blink_q, blink_d;

  assign blink_d = edit ? (blink_q ^ blink_tick) : 1'b0;

  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) blink_q <= 1'b0;
    else       blink_q <= blink_d;
  end

  always_comb begin
    mapa_out = mapa_q;
    if (blink_q) begin
      for (int unsigned c = 0; c < N_COLS; c++) begin
        if (cursor_col_q == COL_W'(c)) mapa_out[c] = mapa_q[c] ^ row_mask;
      end
    end
  end
`else
  logic unused_blink;
  assign unused_blink = blink_tick;
  assign mapa_out     = mapa_q;
`endif

  logic unused_inputs;
  assign unused_inputs = ^{ch[6:2], level};

  assign mapa0       = mapa_out[0];
  assign mapa1       = mapa_out[1];
  assign mapa2       = mapa_out[2];
  assign mapa3       = mapa_out[3];
  assign mapa4       = mapa_out[4];
  assign cursor_col  = cursor_col_q;
  assign cursor_row  = cursor_row_q;
  assign modo_edicao = edit;

endmodule

// File: tb/tb_editor_mapa.sv
// tb_editor_mapa: table of button/switch actions with hand-derived expected cursor,
// mode and bitmap; expectations are queued when stimulus is driven and compared once
// the action has had time to settle. Hand-written sequences cover bounce, blink and reset.
module tb_editor_mapa;

  localparam logic [34:0] P0  = {7'b1000011, 7'b1110001, 7'b1000101, 7'b0001100, 7'b0000100};
  localparam logic [34:0] P0T = {7'b1000011, 7'b1110001, 7'b1001101, 7'b0001100, 7'b0000100};
  localparam logic [34:0] P1  = 35'd0;
  localparam logic [34:0] P2  = {7'b1111111, 7'b1000001, 7'b1000001, 7'b1000001, 7'b1111111};
  localparam logic [34:0] P3  = {7'b1010101, 7'b0101010, 7'b1010101, 7'b0101010, 7'b1010101};

`ifdef CURSOR_BLINK_EN
  localparam bit BLINK = 1'b1;
`else
  localparam bit BLINK = 1'b0;
`endif

  logic       clock_in = 1'b0;
  logic       reset;
  logic [3:0] btn;
  logic [7:0] ch;
  logic       blink_tick;
  logic [6:0] mapa0, mapa1, mapa2, mapa3, mapa4;
  logic [2:0] cursor_col, cursor_row;
  logic       modo_edicao;

  always #5 clock_in = ~clock_in;

  editor_mapa #(
    .DB_CYCLES(4),
    .DB_W     (3)
  ) dut (
    .clock_in   (clock_in),
    .reset      (reset),
    .btn        (btn),
    .ch         (ch),
    .blink_tick (blink_tick),
    .mapa0      (mapa0),
    .mapa1      (mapa1),
    .mapa2      (mapa2),
    .mapa3      (mapa3),
    .mapa4      (mapa4),
    .cursor_col (cursor_col),
    .cursor_row (cursor_row),
    .modo_edicao(modo_edicao)
  );

  typedef struct {
    logic [3:0]  press;
    logic [7:0]  ch;
    logic [2:0]  col;
    logic [2:0]  row;
    logic        mode;
    logic [34:0] mapa;
  } vec_t;

  vec_t vecs[32];
  vec_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic vec_t mk(logic [3:0] p, logic [7:0] c, logic [2:0] col, logic [2:0] row,
                              logic m, logic [34:0] map);
    vec_t v;
    v.press = p; v.ch = c; v.col = col; v.row = row; v.mode = m; v.mapa = map;
    return v;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clock_in);
    #1;
  endtask

  task automatic press_btn(input logic [3:0] mask);
    btn = ~mask;
    tick(10);
    btn = 4'hF;
    tick(10);
  endtask

  task automatic set_ch(input logic [7:0] v);
    ch = v;
    tick(6);
  endtask

  task automatic pulse_blink();
    blink_tick = 1'b1;
    tick(1);
    blink_tick = 1'b0;
    tick(2);
  endtask

  task automatic push_exp(input logic [2:0] col, input logic [2:0] row, input logic m,
                          input logic [34:0] map);
    exp_q.push_back(mk(4'h0, 8'h00, col, row, m, map));
  endtask

  task automatic cmp(input string nm, input logic [34:0] act, input logic [34:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, want);
    end
  endtask

  task automatic check(input string nm);
    vec_t e;
    @(negedge clock_in);
    if (exp_q.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: scoreboard empty, got nothing to compare, expected one entry", nm);
    end else begin
      e = exp_q.pop_front();
      cmp({nm, ".col"},  35'(cursor_col),  35'(e.col));
      cmp({nm, ".row"},  35'(cursor_row),  35'(e.row));
      cmp({nm, ".mode"}, 35'(modo_edicao), 35'(e.mode));
      cmp({nm, ".mapa"}, {mapa4, mapa3, mapa2, mapa1, mapa0}, e.mapa);
    end
    tick(1);
  endtask

  initial begin
    // press mask bit i = button i; ch[7] = edit, ch[1:0] = preset
    vecs[0]  = mk(4'h0, 8'h80, 3'd0, 3'd0, 1'b1, P0);
    vecs[1]  = mk(4'h1, 8'h80, 3'd1, 3'd0, 1'b1, P0);
    vecs[2]  = mk(4'h1, 8'h80, 3'd2, 3'd0, 1'b1, P0);
    vecs[3]  = mk(4'h1, 8'h80, 3'd3, 3'd0, 1'b1, P0);
    vecs[4]  = mk(4'h1, 8'h80, 3'd4, 3'd0, 1'b1, P0);
    vecs[5]  = mk(4'h1, 8'h80, 3'd0, 3'd0, 1'b1, P0);
    vecs[6]  = mk(4'h2, 8'h80, 3'd0, 3'd1, 1'b1, P0);
    vecs[7]  = mk(4'h2, 8'h80, 3'd0, 3'd2, 1'b1, P0);
    vecs[8]  = mk(4'h2, 8'h80, 3'd0, 3'd3, 1'b1, P0);
    vecs[9]  = mk(4'h2, 8'h80, 3'd0, 3'd4, 1'b1, P0);
    vecs[10] = mk(4'h2, 8'h80, 3'd0, 3'd5, 1'b1, P0);
    vecs[11] = mk(4'h2, 8'h80, 3'd0, 3'd6, 1'b1, P0);
    vecs[12] = mk(4'h2, 8'h80, 3'd0, 3'd0, 1'b1, P0);
    vecs[13] = mk(4'h1, 8'h80, 3'd1, 3'd0, 1'b1, P0);
    vecs[14] = mk(4'h1, 8'h80, 3'd2, 3'd0, 1'b1, P0);
    vecs[15] = mk(4'h2, 8'h80, 3'd2, 3'd1, 1'b1, P0);
    vecs[16] = mk(4'h2, 8'h80, 3'd2, 3'd2, 1'b1, P0);
    vecs[17] = mk(4'h2, 8'h80, 3'd2, 3'd3, 1'b1, P0);
    vecs[18] = mk(4'h4, 8'h80, 3'd2, 3'd3, 1'b1, P0T);
    vecs[19] = mk(4'h4, 8'h80, 3'd2, 3'd3, 1'b1, P0);
    vecs[20] = mk(4'h0, 8'h02, 3'd2, 3'd3, 1'b0, P0);
    vecs[21] = mk(4'h4, 8'h02, 3'd2, 3'd3, 1'b0, P0);
    vecs[22] = mk(4'h8, 8'h02, 3'd2, 3'd3, 1'b0, P2);
    vecs[23] = mk(4'h0, 8'h83, 3'd2, 3'd3, 1'b1, P2);
    vecs[24] = mk(4'hC, 8'h83, 3'd2, 3'd3, 1'b1, P3);
    vecs[25] = mk(4'h3, 8'h83, 3'd3, 3'd4, 1'b1, P3);
    vecs[26] = mk(4'h8, 8'h81, 3'd3, 3'd4, 1'b1, P1);
    vecs[27] = mk(4'h1, 8'h81, 3'd4, 3'd4, 1'b1, P1);
    vecs[28] = mk(4'h1, 8'h81, 3'd0, 3'd4, 1'b1, P1);
    vecs[29] = mk(4'h2, 8'h81, 3'd0, 3'd5, 1'b1, P1);
    vecs[30] = mk(4'h2, 8'h81, 3'd0, 3'd6, 1'b1, P1);
    vecs[31] = mk(4'h2, 8'h81, 3'd0, 3'd0, 1'b1, P1);

    reset = 1'b1; btn = 4'hF; ch = 8'h00; blink_tick = 1'b0;
    tick(3);
    push_exp(3'd0, 3'd0, 1'b0, P0);
    check("reset");
    reset = 1'b0;
    tick(2);
    push_exp(3'd0, 3'd0, 1'b0, P0);
    check("post_reset");

    for (int i = 0; i < 32; i++) begin
      exp_q.push_back(vecs[i]);
      set_ch(vecs[i].ch);
      if (vecs[i].press != 4'h0) press_btn(vecs[i].press);
      check($sformatf("vec%0d", i));
    end

    // Blink at cursor (0,0) on an all-off map.
    push_exp(3'd0, 3'd0, 1'b1, BLINK ? 35'd1 : 35'd0);
    pulse_blink();
    check("blink1");
    push_exp(3'd0, 3'd0, 1'b1, 35'd0);
    pulse_blink();
    check("blink2");

    // Bounces shorter than the debounce window, then a solid press: one row step.
    push_exp(3'd0, 3'd1, 1'b1, 35'd0);
    for (int k = 0; k < 2; k++) begin
      btn[1] = 1'b0; tick(2);
      btn[1] = 1'b1; tick(2);
    end
    btn[1] = 1'b0; tick(10);
    btn[1] = 1'b1; tick(10);
    check("bounce");

    push_exp(3'd0, 3'd1, 1'b1, BLINK ? 35'd2 : 35'd0);
    pulse_blink();
    check("blink3");
    // Leaving EDIT clears the phase; the cursor pixel shows the stored value.
    push_exp(3'd0, 3'd1, 1'b0, 35'd0);
    set_ch(8'h00);
    check("blink_exit");

    // Re-enter EDIT, toggle (0,1), then reset in the middle of a debounce.
    push_exp(3'd0, 3'd1, 1'b1, 35'd2);
    set_ch(8'h80);
    press_btn(4'h4);
    check("toggle_01");
    push_exp(3'd0, 3'd0, 1'b0, P0);
    btn = 4'hE;
    tick(3);
    reset = 1'b1;
    tick(1);
    check("reset_mid");
    push_exp(3'd0, 3'd0, 1'b0, P0);
    btn = 4'hF;
    ch = 8'h00;
    tick(2);
    reset = 1'b0;
    tick(12);
    check("after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
